// File: rtl/wave_meas_pkg.sv
// rtl/wave_meas_pkg.sv - shared types and default constants for wave_meas
package wave_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } wave_meas_state_t;

    localparam int WM_DATA_W   = 12;
    localparam int WM_WIN_LOG2 = 5;
    localparam int WM_NCH      = 2;

endpackage

// File: rtl/wave_meas_if.sv
// rtl/wave_meas_if.sv - sample input and measurement result bundle for wave_meas
interface wave_meas_if
    import wave_meas_pkg::*;
#(
    parameter int DATA_W = WM_DATA_W,
    parameter int NCH    = WM_NCH
) ();

    logic                  in_valid;
    logic [NCH*DATA_W-1:0] in_data;
    logic                  out_valid;
    logic [NCH*DATA_W-1:0] meas_max;
    logic [NCH*DATA_W-1:0] meas_min;
    logic [NCH*DATA_W-1:0] meas_p2p;
    logic [NCH*DATA_W-1:0] meas_mean;

    modport master (
        output in_valid, in_data,
        input  out_valid, meas_max, meas_min, meas_p2p, meas_mean
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, meas_max, meas_min, meas_p2p, meas_mean
    );

endinterface

// File: rtl/wave_meas_ch.sv
// rtl/wave_meas_ch.sv - one channel's running max/min/sum and window result registers
module wave_meas_ch
    import wave_meas_pkg::*;
#(
    parameter int DATA_W   = WM_DATA_W,
    parameter int WIN_LOG2 = WM_WIN_LOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              first,
    input  logic              last,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] res_max,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_p2p,
    output logic [DATA_W-1:0] res_mean
);

    localparam int SUM_W = DATA_W + WIN_LOG2;

    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] run_min;
    logic [SUM_W-1:0]  run_sum;
    logic [DATA_W-1:0] nxt_max;
    logic [DATA_W-1:0] nxt_min;
    logic [SUM_W-1:0]  nxt_sum;

    // The first sample of a window replaces the running values outright.
    always_comb begin
        nxt_max = sample;
        nxt_min = sample;
        nxt_sum = SUM_W'(sample);
        if (!first) begin
            nxt_max = (sample > run_max) ? sample : run_max;
            nxt_min = (sample < run_min) ? sample : run_min;
            nxt_sum = run_sum + SUM_W'(sample);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max  <= '0;
            run_min  <= '1;
            run_sum  <= '0;
            res_max  <= '0;
            res_min  <= '0;
            res_p2p  <= '0;
            res_mean <= '0;
        end else if (accept) begin
            if (last) begin
                run_max  <= '0;
                run_min  <= '1;
                run_sum  <= '0;
                res_max  <= nxt_max;
                res_min  <= nxt_min;
                res_p2p  <= nxt_max - nxt_min;
                res_mean <= nxt_sum[SUM_W-1 -: DATA_W];
            end else begin
                run_max <= nxt_max;
                run_min <= nxt_min;
                run_sum <= nxt_sum;
            end
        end
    end

endmodule

// File: rtl/wave_meas.sv
// rtl/wave_meas.sv - multi-channel windowed max/min/p2p/mean measurement, continuous or single-shot
module wave_meas
    import wave_meas_pkg::*;
#(
    parameter int DATA_W   = WM_DATA_W,
    parameter int WIN_LOG2 = WM_WIN_LOG2,
    parameter int NCH      = WM_NCH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              single,
    input  logic              arm,
    wave_meas_if.slave        bus,
    output logic              busy
);

    logic [1:0]          rst_sync;
    logic                rst_int;
    wave_meas_state_t    state;
    wave_meas_state_t    state_nxt;
    logic [WIN_LOG2-1:0] cnt;
    logic                accept;
    logic                first;
    logic                last;
    logic                out_valid_q;

    logic [NCH*DATA_W-1:0] res_max;
    logic [NCH*DATA_W-1:0] res_min;
    logic [NCH*DATA_W-1:0] res_p2p;
    logic [NCH*DATA_W-1:0] res_mean;

    // Assertion is immediate; deassertion is retimed through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int = rst_sync[1];

    assign accept = bus.in_valid && (state == RUN);
    assign first  = (cnt == '0);
    assign last   = &cnt;
    assign busy   = (state == RUN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!single || arm) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && last && single) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (arm) begin
                    state_nxt = RUN;
                end else if (!single) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_valid_q <= accept && last;
            if (accept) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        wave_meas_ch #(
            .DATA_W   (DATA_W),
            .WIN_LOG2 (WIN_LOG2)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_int),
            .accept   (accept),
            .first    (first),
            .last     (last),
            .sample   (bus.in_data[k*DATA_W +: DATA_W]),
            .res_max  (res_max[k*DATA_W +: DATA_W]),
            .res_min  (res_min[k*DATA_W +: DATA_W]),
            .res_p2p  (res_p2p[k*DATA_W +: DATA_W]),
            .res_mean (res_mean[k*DATA_W +: DATA_W])
        );
    end

    assign bus.out_valid = out_valid_q;
    assign bus.meas_max  = res_max;
    assign bus.meas_min  = res_min;
    assign bus.meas_p2p  = res_p2p;
    assign bus.meas_mean = res_mean;

endmodule
